// File: rtl/buf_exchange_hub_if.sv
// Buffer-exchange bus between the cores and the shared hub.
// Cores drive the master side; the hub uses the slave side.
interface buf_exchange_hub_if #(
  parameter int unsigned NUM_CORES = 8
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned EW = 8;

  logic [DW*NUM_CORES-1:0] core_buf_val_1;
  logic [DW*NUM_CORES-1:0] core_buf_val_2;
  logic [NUM_CORES-1:0]    core_buf_flag;
  logic [AW*NUM_CORES-1:0] core_addr_1;
  logic [AW*NUM_CORES-1:0] core_addr_2;
  logic [DW*NUM_CORES-1:0] core_select_1;
  logic [DW*NUM_CORES-1:0] core_select_2;
  logic                    all_buf_flags;
  logic [EW-1:0]           epoch;
  logic                    hub_timeout;

  modport master (
    output core_buf_val_1, core_buf_val_2, core_buf_flag, core_addr_1, core_addr_2,
    input  core_select_1, core_select_2, all_buf_flags, epoch, hub_timeout
  );

  modport slave (
    input  core_buf_val_1, core_buf_val_2, core_buf_flag, core_addr_1, core_addr_2,
    output core_select_1, core_select_2, all_buf_flags, epoch, hub_timeout
  );
endinterface

// File: rtl/buf_exchange_hub.sv
// Shared buffer-exchange hub: per-core slot snapshot, combinational slot reads, flag barrier.
// Optional watchdog enabled by defining BUF_HUB_TIMEOUT_EN.
module buf_exchange_hub #(
  parameter int unsigned          NUM_CORES   = 8,
  parameter logic [NUM_CORES-1:0] CORE_MASK   = '1,
  parameter int unsigned          TIMEOUT_CYC = 1024
) (
  input logic               Clk,
  input logic               Reset,
  buf_exchange_hub_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned EW = 8;

  typedef enum logic {COLLECT, RELEASE} state_t;

  state_t               state;
  logic [NUM_CORES-1:0] posted;
  logic [NUM_CORES-1:0] seen_low;
  logic [DW-1:0]        slot_v1 [NUM_CORES];
  logic [DW-1:0]        slot_v2 [NUM_CORES];
  logic                 all_flags_q;
  logic [EW-1:0]        epoch_q;

  logic                 all_posted_c;
  logic                 all_low_c;
  logic [NUM_CORES-1:0] capture_c;
  logic [DW*NUM_CORES-1:0] sel1_c;
  logic [DW*NUM_CORES-1:0] sel2_c;

  assign all_posted_c = ((posted & CORE_MASK) == CORE_MASK);
  assign all_low_c    = ((seen_low & CORE_MASK) == CORE_MASK);
  assign capture_c    = CORE_MASK & bus.core_buf_flag & ~posted;

`ifdef BUF_HUB_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_q;
  logic           timeout_q;
  logic           wd_run_c;
  logic           wd_fire_c;

  assign wd_run_c  = (state == COLLECT) && ((posted & CORE_MASK) != '0);
  assign wd_fire_c = wd_run_c && (wd_q == WDW'(TIMEOUT_CYC - 1));
`endif

  // Barrier state machine, slot capture and registered status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= COLLECT;
      posted      <= '0;
      seen_low    <= '0;
      all_flags_q <= 1'b0;
      epoch_q     <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_v1[i] <= '0;
        slot_v2[i] <= '0;
      end
`ifdef BUF_HUB_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (capture_c[i]) begin
              slot_v1[i] <= bus.core_buf_val_1[DW*i +: DW];
              slot_v2[i] <= bus.core_buf_val_2[DW*i +: DW];
              posted[i]  <= 1'b1;
            end
          end
          if (all_posted_c) begin
            state       <= RELEASE;
            all_flags_q <= 1'b1;
          end
`ifdef BUF_HUB_TIMEOUT_EN
          if (wd_run_c) wd_q <= wd_q + WDW'(1);
          // Forced release: cores that never posted expose zero for this epoch
          if (wd_fire_c) begin
            timeout_q   <= 1'b1;
            state       <= RELEASE;
            all_flags_q <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (!posted[i] && !capture_c[i]) begin
                slot_v1[i] <= '0;
                slot_v2[i] <= '0;
              end
            end
          end
`endif
        end
        RELEASE: begin
          // Flags only need to have been low once, not simultaneously
          if (all_low_c) begin
            state       <= COLLECT;
            posted      <= '0;
            seen_low    <= '0;
            all_flags_q <= 1'b0;
            epoch_q     <= epoch_q + EW'(1);
`ifdef BUF_HUB_TIMEOUT_EN
            wd_q        <= '0;
`endif
          end else begin
            seen_low <= seen_low | ~bus.core_buf_flag;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // Same-cycle slot reads; out-of-range or masked addresses return zero
  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (CORE_MASK[j] && (bus.core_addr_1[AW*i +: AW] == AW'(j)))
          sel1_c[DW*i +: DW] = slot_v1[j];
        if (CORE_MASK[j] && (bus.core_addr_2[AW*i +: AW] == AW'(j)))
          sel2_c[DW*i +: DW] = slot_v2[j];
      end
    end
  end

  assign bus.core_select_1 = sel1_c;
  assign bus.core_select_2 = sel2_c;
  assign bus.all_buf_flags = all_flags_q;
  assign bus.epoch         = epoch_q;

`ifdef BUF_HUB_TIMEOUT_EN
  assign bus.hub_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign bus.hub_timeout    = 1'b0;
`endif
endmodule
